// File: rtl/ibex_vector_load_unit.sv
// ibex_vector_load_unit
// Fetches 1, 2 or 4 consecutive 32b words from data memory for a unit-stride
// vector load into a 128b staging buffer, then issues a single VRF write beat.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   vld_start_i          start pulse, only sampled while idle
//   vld_base_addr_i      byte address of element 0 (must be word aligned)
//   vld_vd_i             destination register (group base)
//   vlmul_i              000=1, 001=2, 010=4 registers, others reserved
//   vld_busy_o           high whenever not idle
//   vld_done_o           1-cycle pulse when the load commits
//   vld_err_o            1-cycle pulse when the load is rejected or aborted
//   data_req_o/addr_o    memory request, held until data_gnt_i
//   data_gnt_i           request accepted
//   data_rvalid_i/rdata_i/err_i  memory response
//   v_wdata_o            staged data, slot s = bits [32s+31:32s]
//   v_waddr_o            captured vd
//   v_we_o, v_load_en_o  VRF write strobe (suppressed for v0)
//   v_wnum_o             thermometer word count 0001/0011/1111
//   vld_fault_addr_o     (IBEX_VLD_FAULT_ADDR_EN only) address of the last error
//
// Optional feature macro: IBEX_VLD_FAULT_ADDR_EN
module ibex_vector_load_unit #(
  parameter int unsigned VLEN     = 32,
  parameter int unsigned NUM_SLOT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     vld_start_i,
  input  logic [31:0]              vld_base_addr_i,
  input  logic [4:0]               vld_vd_i,
  input  logic [2:0]               vlmul_i,
  output logic                     vld_busy_o,
  output logic                     vld_done_o,
  output logic                     vld_err_o,
  output logic                     data_req_o,
  output logic [31:0]              data_addr_o,
  input  logic                     data_gnt_i,
  input  logic                     data_rvalid_i,
  input  logic [VLEN-1:0]          data_rdata_i,
  input  logic                     data_err_i,
  output logic [NUM_SLOT*VLEN-1:0] v_wdata_o,
  output logic [4:0]               v_waddr_o,
  output logic                     v_we_o,
  output logic [3:0]               v_wnum_o,
`ifdef IBEX_VLD_FAULT_ADDR_EN
  output logic [31:0]              vld_fault_addr_o,
`endif
  output logic                     v_load_en_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [31:0]                base_q;
  logic [4:0]                 vd_q;
  logic [1:0]                 k_q;          // index of the word being fetched
  logic [1:0]                 last_k_q;     // N-1
  logic [1:0]                 slot_base_q;  // B
  logic [3:0]                 wnum_q;
  logic [NUM_SLOT*VLEN-1:0]   buf_q;
  logic                       err_q;

  // Command decode for the start request
  logic                       cmd_ok;
  logic [1:0]                 dec_last_k;
  logic [1:0]                 dec_slot_base;
  logic [3:0]                 dec_wnum;
  logic                       lmul_ok;

  always_comb begin
    lmul_ok       = 1'b1;
    dec_last_k    = 2'd0;
    dec_slot_base = 2'd0;
    dec_wnum      = 4'b0000;
    case (vlmul_i)
      3'b000: begin
        dec_last_k    = 2'd0;
        dec_slot_base = vld_vd_i[1:0];
        dec_wnum      = 4'b0001;
      end
      3'b001: begin
        dec_last_k    = 2'd1;
        dec_slot_base = {vld_vd_i[1], 1'b0};
        dec_wnum      = 4'b0011;
      end
      3'b010: begin
        dec_last_k    = 2'd3;
        dec_slot_base = 2'd0;
        dec_wnum      = 4'b1111;
      end
      default: lmul_ok = 1'b0;
    endcase
    cmd_ok = lmul_ok && (vld_base_addr_i[1:0] == 2'b00);
  end

  logic [31:0] cur_addr;
  logic [1:0]  wr_slot;
  assign cur_addr = base_q + {28'd0, k_q, 2'b00};
  assign wr_slot  = slot_base_q + k_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (vld_start_i && cmd_ok) state_d = REQ;
      REQ:   if (data_gnt_i) state_d = WAIT;
      WAIT: begin
        if (data_rvalid_i) begin
          if (data_err_i)             state_d = IDLE;
          else if (k_q == last_k_q)   state_d = WRITE;
          else                        state_d = REQ;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q      <= '0;
      vd_q        <= '0;
      k_q         <= '0;
      last_k_q    <= '0;
      slot_base_q <= '0;
      wnum_q      <= '0;
      buf_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vld_start_i) begin
            if (!cmd_ok) begin
              err_q <= 1'b1;
            end else begin
              base_q      <= vld_base_addr_i;
              vd_q        <= vld_vd_i;
              k_q         <= '0;
              last_k_q    <= dec_last_k;
              slot_base_q <= dec_slot_base;
              wnum_q      <= dec_wnum;
              buf_q       <= '0;
            end
          end
        end
        WAIT: begin
          if (data_rvalid_i) begin
            if (data_err_i) begin
              err_q <= 1'b1;
            end else begin
              for (int unsigned s = 0; s < NUM_SLOT; s++) begin
                if (wr_slot == 2'(s)) buf_q[s*VLEN +: VLEN] <= data_rdata_i;
              end
              k_q <= k_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IBEX_VLD_FAULT_ADDR_EN
  logic [31:0] fault_addr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_addr_q <= '0;
    end else if (state_q == IDLE && vld_start_i && !cmd_ok) begin
      fault_addr_q <= vld_base_addr_i;
    end else if (state_q == WAIT && data_rvalid_i && data_err_i) begin
      fault_addr_q <= cur_addr;
    end
  end
  assign vld_fault_addr_o = fault_addr_q;
`endif

  assign vld_busy_o  = (state_q != IDLE);
  assign vld_done_o  = (state_q == WRITE);
  assign vld_err_o   = err_q;
  assign data_req_o  = (state_q == REQ);
  assign data_addr_o = (state_q == REQ) ? cur_addr : '0;
  assign v_we_o      = (state_q == WRITE) && (vd_q != 5'd0);
  assign v_load_en_o = v_we_o;
  assign v_wdata_o   = buf_q;
  assign v_waddr_o   = vd_q;
  assign v_wnum_o    = wnum_q;

`ifndef SYNTHESIS
  // A response outside WAIT is a bus protocol violation; it is dropped.
  rvalid_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_i |-> (state_q == WAIT))
    else $warning("vld: rvalid received outside WAIT, dropped");
`endif

endmodule

// File: tb/tb_ibex_vector_load_unit.sv
module tb_ibex_vector_load_unit;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         vld_start_i;
  logic [31:0]  vld_base_addr_i;
  logic [4:0]   vld_vd_i;
  logic [2:0]   vlmul_i;
  logic         vld_busy_o, vld_done_o, vld_err_o;
  logic         data_req_o;
  logic [31:0]  data_addr_o;
  logic         data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0]  data_rdata_i;
  logic [127:0] v_wdata_o;
  logic [4:0]   v_waddr_o;
  logic         v_we_o, v_load_en_o;
  logic [3:0]   v_wnum_o;
`ifdef IBEX_VLD_FAULT_ADDR_EN
  logic [31:0]  vld_fault_addr_o;
`endif

  always #5 clk_i = ~clk_i;

  ibex_vector_load_unit #(.VLEN(32), .NUM_SLOT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .vld_start_i(vld_start_i), .vld_base_addr_i(vld_base_addr_i),
    .vld_vd_i(vld_vd_i), .vlmul_i(vlmul_i),
    .vld_busy_o(vld_busy_o), .vld_done_o(vld_done_o), .vld_err_o(vld_err_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .v_wdata_o(v_wdata_o), .v_waddr_o(v_waddr_o), .v_we_o(v_we_o), .v_wnum_o(v_wnum_o),
`ifdef IBEX_VLD_FAULT_ADDR_EN
    .vld_fault_addr_o(vld_fault_addr_o),
`endif
    .v_load_en_o(v_load_en_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Responder memory and run observations
  logic [31:0] mem [0:3];
  logic [31:0] req_addr [0:7];
  int          req_cnt;
  int          write_cyc, err_cyc, unstable, we_en_diff;
  bit          saw_we, saw_done, saw_err, saw_req, busy_at_err, finished;

  task automatic do_reset();
    rst_ni = 1'b0;
    vld_start_i = 0; vld_base_addr_i = '0; vld_vd_i = '0; vlmul_i = '0;
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // Issues a start and plays the memory side until done/err or a cycle budget.
  // Cycle 0 is the cycle in which the start is sampled.
  task automatic run_load(input logic [31:0] base, input logic [4:0] vd,
                          input logic [2:0] lmul, input int gdly, input int err_idx);
    int  cyc, waited, pidx;
    bit  pend, waiting;
    logic [31:0] last_addr;
    cyc = 0; waited = 0; pidx = 0; pend = 0; waiting = 0; last_addr = '0;
    req_cnt = 0; write_cyc = -1; err_cyc = -1; unstable = 0; we_en_diff = 0;
    saw_we = 0; saw_done = 0; saw_err = 0; saw_req = 0; busy_at_err = 1; finished = 0;
    vld_start_i = 1; vld_base_addr_i = base; vld_vd_i = vd; vlmul_i = lmul;
    while (cyc < 60 && !finished) begin
      @(negedge clk_i);
      cyc++;
      vld_start_i = 0;
      data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0;
      if (pend) begin
        data_rvalid_i = 1;
        data_rdata_i  = mem[pidx];
        data_err_i    = (pidx == err_idx);
        pend = 0;
      end
      if (data_req_o) begin
        saw_req = 1;
        if (waiting && data_addr_o !== last_addr) unstable++;
        if (waited >= gdly) begin
          data_gnt_i = 1;
          if (req_cnt < 8) req_addr[req_cnt] = data_addr_o;
          req_cnt++;
          pidx = int'((data_addr_o - base) >> 2) & 3;
          pend = 1; waited = 0; waiting = 0;
        end else begin
          waited++; waiting = 1; last_addr = data_addr_o;
        end
      end
      if (v_we_o) saw_we = 1;
      if (v_we_o !== v_load_en_o) we_en_diff++;
      if (vld_done_o) begin saw_done = 1; write_cyc = cyc; finished = 1; end
      if (vld_err_o) begin saw_err = 1; err_cyc = cyc; busy_at_err = vld_busy_o; finished = 1; end
    end
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0;
    check_val("run_terminates", 128'(finished), 128'd1);
    @(negedge clk_i);
  endtask

  initial begin
    do_reset();

    // Reset state
    check_val("rst_busy",  128'(vld_busy_o), 0);
    check_val("rst_done",  128'(vld_done_o), 0);
    check_val("rst_err",   128'(vld_err_o), 0);
    check_val("rst_req",   128'(data_req_o), 0);
    check_val("rst_addr",  128'(data_addr_o), 0);
    check_val("rst_wdata", v_wdata_o, 0);
    check_val("rst_waddr", 128'(v_waddr_o), 0);
    check_val("rst_we",    128'({v_we_o, v_load_en_o}), 0);
    check_val("rst_wnum",  128'(v_wnum_o), 0);

    // lmul1, vd=6, base 0x100
    mem[0] = 32'hA5A5_0001; mem[1] = '0; mem[2] = '0; mem[3] = '0;
    run_load(32'h100, 5'd6, 3'b000, 0, -1);
    check_val("l1_write_cyc", 128'(write_cyc), 3);
    check_val("l1_reqs",      128'(req_cnt), 1);
    check_val("l1_addr0",     128'(req_addr[0]), 32'h100);
    check_val("l1_wdata",     v_wdata_o, 128'h00000000_A5A50001_00000000_00000000);
    check_val("l1_wnum",      128'(v_wnum_o), 4'b0001);
    check_val("l1_waddr",     128'(v_waddr_o), 6);
    check_val("l1_we_done",   128'({saw_we, saw_done, we_en_diff == 0}), 3'b111);

    // lmul4, vd=8, base 0x200
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    run_load(32'h200, 5'd8, 3'b010, 0, -1);
    check_val("l4_write_cyc", 128'(write_cyc), 9);
    check_val("l4_reqs",      128'(req_cnt), 4);
    check_val("l4_addrs",     {req_addr[0], req_addr[1], req_addr[2], req_addr[3]},
                              {32'h200, 32'h204, 32'h208, 32'h20C});
    check_val("l4_wdata",     v_wdata_o, 128'h00000044_00000033_00000022_00000011);
    check_val("l4_wnum",      128'(v_wnum_o), 4'b1111);

    // lmul2, vd=3, grant delayed 3 cycles
    mem[0] = 32'hDEAD_0001; mem[1] = 32'hDEAD_0002;
    run_load(32'h300, 5'd3, 3'b001, 3, -1);
    check_val("l2_stable",    128'(unstable), 0);
    check_val("l2_write_cyc", 128'(write_cyc), 11);
    check_val("l2_addrs",     {req_addr[0], req_addr[1]}, {32'h300, 32'h304});
    check_val("l2_wdata",     v_wdata_o, 128'hDEAD0002_DEAD0001_00000000_00000000);
    check_val("l2_wnum",      128'(v_wnum_o), 4'b0011);
    check_val("l2_waddr",     128'(v_waddr_o), 3);

    // lmul2, error on the second response
    mem[0] = 32'hCAFE_0001; mem[1] = 32'hCAFE_0002;
    run_load(32'h400, 5'd2, 3'b001, 0, 1);
    check_val("be_err",      128'(saw_err), 1);
    check_val("be_err_cyc",  128'(err_cyc), 5);
    check_val("be_no_write", 128'({saw_we, saw_done}), 0);
    check_val("be_busy",     128'(busy_at_err), 0);
    check_val("be_partial",  v_wdata_o, 128'h00000000_CAFE0001_00000000_00000000);
`ifdef IBEX_VLD_FAULT_ADDR_EN
    check_val("be_fault",    128'(vld_fault_addr_o), 32'h404);
`endif

    // Misaligned base
    run_load(32'h102, 5'd4, 3'b000, 0, -1);
    check_val("al_err_cyc",  128'(err_cyc), 1);
    check_val("al_no_req",   128'(saw_req), 0);
    check_val("al_busy",     128'(busy_at_err), 0);
`ifdef IBEX_VLD_FAULT_ADDR_EN
    check_val("al_fault",    128'(vld_fault_addr_o), 32'h102);
`endif

    // Reserved vlmul
    run_load(32'h100, 5'd4, 3'b011, 0, -1);
    check_val("rl_err_cyc",  128'(err_cyc), 1);
    check_val("rl_no_req",   128'(saw_req), 0);

    // vd=0: load completes, write suppressed
    mem[0] = 32'h0000_BEEF;
    run_load(32'h600, 5'd0, 3'b000, 0, -1);
    check_val("v0_done",     128'(saw_done), 1);
    check_val("v0_no_we",    128'(saw_we), 0);
    check_val("v0_wdata",    v_wdata_o, 128'h0000BEEF);

    // Async reset while waiting for the response
    vld_start_i = 1; vld_base_addr_i = 32'h500; vld_vd_i = 5'd5; vlmul_i = 3'b000;
    @(negedge clk_i);                 // REQ
    vld_start_i = 0;
    check_val("ar_req", 128'({data_req_o, data_addr_o}), {1'b1, 32'h500});
    data_gnt_i = 1;
    @(negedge clk_i);                 // WAIT
    data_gnt_i = 0;
    check_val("ar_in_wait", 128'({vld_busy_o, data_req_o}), 2'b10);
    #1 rst_ni = 1'b0;
    #1;
    check_val("ar_outputs", 128'({vld_busy_o, vld_done_o, vld_err_o, data_req_o,
                                  v_we_o, v_load_en_o, v_wnum_o, v_waddr_o}), 0);
    check_val("ar_wdata", v_wdata_o, 0);
    data_rvalid_i = 1; data_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    data_rvalid_i = 0;
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check_val("ar_idle", 128'({vld_busy_o, vld_done_o, v_we_o}), 0);
    end
    check_val("ar_wdata_after", v_wdata_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
